// File: rtl/lib_switch_allocator_rr_pkg.sv
// Shared types and constants for the round-robin switch allocator.
package lib_switch_pkg;

   localparam int N_DEF = 4;
   localparam int M_DEF = 4;
   localparam int PTR_W = $clog2(N_DEF);

   typedef logic [0:N_DEF-1] sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/lib_switch_allocator_rr_if.sv
// Request/select bundle between input buffers, allocator and crossbar.
interface lib_switch_allocator_rr_if #(
   parameter int N = 4,
   parameter int M = 4
);
   logic [0:N-1][0:M-1] i_req;
   logic [0:N-1]        i_tail;
   logic [0:M-1]        i_out_ready;
   logic [0:M-1][0:N-1] o_sel;
   logic [0:N-1]        o_grant;
   logic [0:M-1]        o_out_valid;

   modport master (
      output i_req, i_tail, i_out_ready,
      input  o_sel, o_grant, o_out_valid
   );

   modport slave (
      input  i_req, i_tail, i_out_ready,
      output o_sel, o_grant, o_out_valid
   );

   modport mon (
      input i_req, i_tail, i_out_ready, o_sel, o_grant, o_out_valid
   );
endinterface

// File: rtl/lib_switch_allocator_rr_arbiter.sv
// Combinational N-way round-robin arbiter: first requester at or after ptr wins.
module lib_arbiter_rr #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [0:N-1]  req,
   input  logic [PW-1:0] ptr,
   output logic [0:N-1]  gnt,
   output logic [PW-1:0] idx,
   output logic          valid
);
   logic [PW-1:0] cand;

   // Scan N positions starting at ptr, wrapping N-1 -> 0; latch the first hit.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = PW'((int'(ptr) + k) % N);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end else begin
            valid = valid;
         end
      end
   end
endmodule

// File: rtl/lib_switch_allocator_rr_chk.sv
// Protocol checker: one output per input request, and o_sel never multi-hot.
module lib_switch_allocator_rr_chk #(
   parameter int N = 4,
   parameter int M = 4
) (
   input logic                    clk,
   input logic                    reset,
   lib_switch_allocator_rr_if.mon bus
);
   // Sampled each rising edge outside reset.
   always @(posedge clk) begin
      if (!reset) begin
         for (int j = 0; j < N; j++) begin
            assert ($onehot0(bus.i_req[j]))
               else $error("input %0d requests several outputs: %b", j, bus.i_req[j]);
         end
         for (int i = 0; i < M; i++) begin
            assert ($onehot0(bus.o_sel[i]))
               else $error("o_sel[%0d] not one-hot: %b", i, bus.o_sel[i]);
         end
      end
   end
endmodule

// File: rtl/lib_switch_allocator_rr.sv
// Per-output round-robin allocator: each output locks to one input from head to tail flit.
module lib_switch_allocator_rr
   import lib_switch_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int M = M_DEF
) (
   input logic                      clk,
   input logic                      reset,
   lib_switch_allocator_rr_if.slave bus
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   state_t              state_r   [M];
   state_t              state_nx  [M];
   logic [PW-1:0]       owner_r   [M];
   logic [PW-1:0]       owner_nx  [M];
   logic [PW-1:0]       ptr_r     [M];
   logic [PW-1:0]       ptr_nx    [M];
   logic [0:N-1]        sel_r     [M];
   logic [0:N-1]        sel_nx    [M];
   logic [0:N-1]        col_req   [M];
   logic [0:N-1]        arb_gnt   [M];
   logic [PW-1:0]       arb_idx   [M];
   logic [0:M-1]        arb_valid;
   logic [0:M-1]        xfer;
   logic [0:N-1][0:M-1] eff_req;
   logic [0:N-1]        seen;
   logic [0:N-1]        grant;

   // A multi-hot request row is trimmed to its lowest-indexed output, then transposed per output.
   always_comb begin
      eff_req = '0;
      seen    = '0;
      for (int i = 0; i < M; i++) begin
         col_req[i] = '0;
      end
      for (int j = 0; j < N; j++) begin
         for (int i = 0; i < M; i++) begin
            eff_req[j][i] = bus.i_req[j][i] & ~seen[j];
            seen[j]       = seen[j] | bus.i_req[j][i];
            col_req[i][j] = eff_req[j][i];
         end
      end
   end

   for (genvar g = 0; g < M; g++) begin : g_arb
      lib_arbiter_rr #(.N(N), .PW(PW)) u_arb (
         .req   (col_req[g]),
         .ptr   (ptr_r[g]),
         .gnt   (arb_gnt[g]),
         .idx   (arb_idx[g]),
         .valid (arb_valid[g])
      );
   end

   // Transfers and the input-side pop: an input owns at most one output, so OR is safe.
   always_comb begin
      xfer  = '0;
      grant = '0;
      for (int i = 0; i < M; i++) begin
         xfer[i] = (state_r[i] == BUSY) & eff_req[owner_r[i]][i] & bus.i_out_ready[i];
         for (int j = 0; j < N; j++) begin
            grant[j] = grant[j] | (xfer[i] & (owner_r[i] == PW'(j)));
         end
      end
   end

   // Drive interface outputs; o_sel comes straight from the select register.
   always_comb begin
      for (int i = 0; i < M; i++) begin
         bus.o_sel[i] = sel_r[i];
      end
      bus.o_grant     = grant;
      bus.o_out_valid = xfer;
   end

   // Per-output FSM next state: arbitrate when idle, hold the lock until the tail moves.
   always_comb begin
      for (int i = 0; i < M; i++) begin
         state_nx[i] = state_r[i];
         owner_nx[i] = owner_r[i];
         ptr_nx[i]   = ptr_r[i];
         sel_nx[i]   = sel_r[i];
         case (state_r[i])
            IDLE: begin
               if (arb_valid[i]) begin
                  state_nx[i] = BUSY;
                  owner_nx[i] = arb_idx[i];
                  ptr_nx[i]   = (arb_idx[i] == PW'(N - 1)) ? '0 : arb_idx[i] + PW'(1);
                  sel_nx[i]   = arb_gnt[i];
               end else begin
                  sel_nx[i] = '0;
               end
            end
            BUSY: begin
               if (xfer[i] && bus.i_tail[owner_r[i]]) begin
                  state_nx[i] = IDLE;
                  sel_nx[i]   = '0;
               end else begin
                  state_nx[i] = BUSY;
               end
            end
            default: begin
               state_nx[i] = IDLE;
               sel_nx[i]   = '0;
            end
         endcase
      end
   end

   // State, owner, pointer and select registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < M; i++) begin
            state_r[i] <= IDLE;
            owner_r[i] <= '0;
            ptr_r[i]   <= '0;
            sel_r[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < M; i++) begin
            state_r[i] <= state_nx[i];
            owner_r[i] <= owner_nx[i];
            ptr_r[i]   <= ptr_nx[i];
            sel_r[i]   <= sel_nx[i];
         end
      end
   end
endmodule

// File: tb/tb_lib_switch_allocator_rr.sv
// Bench for lib_switch_allocator_rr: vector table, corner sequences, random vs. a reference model.
module tb_lib_switch_allocator_rr;
   logic clk = 1'b0;
   logic reset;

   lib_switch_allocator_rr_if #(.N(4), .M(4)) bus ();

   lib_switch_allocator_rr #(.N(4), .M(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: per output a busy flag, owning input and round-robin pointer.
   bit m_busy  [4];
   int m_owner [4];
   int m_ptr   [4];

   typedef struct {
      logic [15:0] req;
      logic [3:0]  tail;
      logic [3:0]  ready;
      logic [15:0] sel;
      logic [3:0]  grant;
      logic [3:0]  valid;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Output an input is asking for (lowest requested one), -1 if none.
   function automatic int target(input int j);
      for (int i = 0; i < 4; i++) begin
         if (bus.i_req[j][i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_busy[i]  = 1'b0;
         m_owner[i] = 0;
         m_ptr[i]   = 0;
      end
   endtask

   task automatic model_exp(output logic [15:0] s, output logic [3:0] g, output logic [3:0] v);
      logic [0:3][0:3] ss;
      logic [0:3]      gg;
      logic [0:3]      vv;
      ss = '0;
      gg = '0;
      vv = '0;
      for (int i = 0; i < 4; i++) begin
         if (m_busy[i]) begin
            ss[i][m_owner[i]] = 1'b1;
            if (target(m_owner[i]) == i && bus.i_out_ready[i]) begin
               vv[i]          = 1'b1;
               gg[m_owner[i]] = 1'b1;
            end
         end
      end
      s = ss;
      g = gg;
      v = vv;
   endtask

   task automatic model_step();
      bit xf [4];
      for (int i = 0; i < 4; i++) begin
         xf[i] = m_busy[i] && target(m_owner[i]) == i && bus.i_out_ready[i];
      end
      for (int i = 0; i < 4; i++) begin
         if (m_busy[i]) begin
            if (xf[i] && bus.i_tail[m_owner[i]]) m_busy[i] = 1'b0;
         end else begin
            for (int k = 0; k < 4; k++) begin
               int j;
               j = (m_ptr[i] + k) % 4;
               if (target(j) == i) begin
                  m_busy[i]  = 1'b1;
                  m_owner[i] = j;
                  m_ptr[i]   = (j + 1) % 4;
                  break;
               end
            end
         end
      end
   endtask

   // One clock: compare against the model at negedge, advance the model at posedge.
   task automatic cycle_model(input string tag, output logic [15:0] sel_o,
                              output logic [3:0] grant_o, output logic [3:0] valid_o);
      logic [15:0] es;
      logic [3:0]  eg;
      logic [3:0]  ev;
      @(negedge clk);
      model_exp(es, eg, ev);
      sel_o   = bus.o_sel;
      grant_o = bus.o_grant;
      valid_o = bus.o_out_valid;
      check({tag, ".sel"},   sel_o, es);
      check({tag, ".grant"}, {12'd0, grant_o}, {12'd0, eg});
      check({tag, ".valid"}, {12'd0, valid_o}, {12'd0, ev});
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      bus.i_req       = '0;
      bus.i_tail      = '0;
      bus.i_out_ready = '0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] s;
      logic [3:0]  g;
      logic [3:0]  v;
      int          flits;
      int          tail_cyc;
      int          g2_cyc;
      int          order [4];

      tbl[0] = '{16'h0000, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0};
      tbl[1] = '{16'h1248, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0};
      tbl[2] = '{16'h1248, 4'hF, 4'hF, 16'h1248, 4'hF, 4'hF};
      tbl[3] = '{16'h0000, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0};
      tbl[4] = '{16'h6000, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0};
      tbl[5] = '{16'h6000, 4'hF, 4'hF, 16'h0800, 4'h8, 4'h4};
      tbl[6] = '{16'h0000, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0};

      do_reset();
      @(negedge clk);
      check("reset.sel",   bus.o_sel, 16'h0000);
      check("reset.grant", {12'd0, bus.o_grant}, 16'h0000);
      check("reset.valid", {12'd0, bus.o_out_valid}, 16'h0000);
      @(posedge clk);
      #1;

      // Parallel allocation and illegal multi-hot request, from the table.
      for (int k = 0; k < 7; k++) begin
         bus.i_req       = tbl[k].req;
         bus.i_tail      = tbl[k].tail;
         bus.i_out_ready = tbl[k].ready;
         @(negedge clk);
         check($sformatf("tbl%0d.sel", k),   bus.o_sel, tbl[k].sel);
         check($sformatf("tbl%0d.grant", k), {12'd0, bus.o_grant}, {12'd0, tbl[k].grant});
         check($sformatf("tbl%0d.valid", k), {12'd0, bus.o_out_valid}, {12'd0, tbl[k].valid});
         @(posedge clk);
         model_step();
         #1;
      end

      // Reset while output 2 is locked to input 1.
      do_reset();
      bus.i_req       = 16'h0200;
      bus.i_tail      = 4'h0;
      bus.i_out_ready = 4'hF;
      cycle_model("rst.arb", s, g, v);
      cycle_model("rst.busy", s, g, v);
      check("rst.locked", bus.o_sel, 16'h0040);
      reset = 1'b1;
      #1;
      check("rst.async_sel",   bus.o_sel, 16'h0000);
      check("rst.async_grant", {12'd0, bus.o_grant}, 16'h0000);
      bus.i_req = '0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      cycle_model("rst.idle0", s, g, v);
      cycle_model("rst.idle1", s, g, v);
      bus.i_req = 16'h0202;
      cycle_model("rst.rearb", s, g, v);
      @(negedge clk);
      check("rst.ptr0", bus.o_sel, 16'h0040);
      @(posedge clk);
      model_step();
      #1;

      // Contention on output 2 from inputs 0,1,3 with single-flit packets.
      do_reset();
      bus.i_req       = 16'h2202;
      bus.i_tail      = 4'hF;
      bus.i_out_ready = 4'hF;
      order = '{0, 1, 3, 0};
      for (int c = 0; c < 8; c++) begin
         cycle_model("cont", s, g, v);
         check($sformatf("cont.order%0d", c), {12'd0, g},
               (c % 2 == 1) ? (16'h0008 >> order[c / 2]) : 16'h0000);
      end

      // Three-flit packet from input 1 to output 0 while input 2 waits.
      do_reset();
      bus.i_req       = 16'h0880;
      bus.i_out_ready = 4'hF;
      flits    = 0;
      tail_cyc = -1;
      g2_cyc   = -1;
      for (int c = 0; c < 12; c++) begin
         bus.i_tail = (flits == 2) ? 4'b0100 : 4'b0000;
         cycle_model("lock", s, g, v);
         if (g == 4'b0100) begin
            check("lock.sel", s, 16'h4000);
            flits++;
            if (flits == 3) begin
               tail_cyc  = c;
               bus.i_req = 16'h0080;
            end
         end
         if (g == 4'b0010 && g2_cyc < 0) g2_cyc = c;
      end
      check("lock.flits",  16'(flits), 16'd3);
      check("lock.bubble", 16'(g2_cyc - tail_cyc), 16'd2);

      // Back-pressure on output 3 with the tail flit waiting.
      do_reset();
      bus.i_req       = 16'h1000;
      bus.i_tail      = 4'b1000;
      bus.i_out_ready = 4'b1110;
      cycle_model("bp.arb", s, g, v);
      for (int c = 0; c < 5; c++) begin
         cycle_model("bp.stall", s, g, v);
         check("bp.stall_grant", {12'd0, g}, 16'h0000);
         check("bp.stall_sel", s, 16'h0008);
      end
      bus.i_out_ready = 4'hF;
      cycle_model("bp.go", s, g, v);
      check("bp.go_grant", {12'd0, g}, 16'h0008);
      check("bp.go_valid", {12'd0, v}, 16'h0001);
      bus.i_req = '0;
      cycle_model("bp.idle", s, g, v);
      check("bp.idle_sel", s, 16'h0000);

      // Random traffic against the reference model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int j = 0; j < 4; j++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)       bus.i_req[j] = 4'b1000 >> $urandom_range(0, 3);
            else if (r == 9) bus.i_req[j] = 4'($urandom_range(0, 15));
            else             bus.i_req[j] = 4'b0000;
         end
         bus.i_tail      = 4'($urandom_range(0, 15));
         bus.i_out_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
         cycle_model("rand", s, g, v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
